mvm_result_drain: RTL and testbench



---
 rtl/mvm_pkg.sv | 46 ++++
 rtl/mvm_result_buf.sv | 30 +++
 rtl/mvm_result_drain.sv | 212 +++++++++++++++++++++
 tb/tb_mvm_result_drain.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvm_pkg.sv
// Shared definitions for the MVM result drain path.
//   mvm_drain_state_t : drain FSM states (IDLE, WAIT, CAPTURE, DRAIN)
//   sat_result_t      : clamped value plus a "clamped" flag
//   sat_trunc()       : signed saturation from in_w bits down to out_w bits
// Values are carried at SAT_MAX_W bits so one function serves any
// IN_W/OUT_W pair up to that width.
package mvm_pkg;

  localparam int SAT_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } mvm_drain_state_t;

  typedef struct packed {
    logic signed [SAT_MAX_W-1:0] value;
    logic                        sat;
  } sat_result_t;

  // value must already be sign-extended from in_w to SAT_MAX_W bits.
  function automatic sat_result_t sat_trunc(input logic signed [SAT_MAX_W-1:0] value,
                                            input int in_w,
                                            input int out_w);
    sat_result_t                 r;
    logic signed [SAT_MAX_W-1:0] hi;
    logic signed [SAT_MAX_W-1:0] lo;
    r.value = value;
    r.sat   = 1'b0;
    if (out_w < in_w) begin
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (value > hi) begin
        r.value = hi;
        r.sat   = 1'b1;
      end else if (value < lo) begin
        r.value = lo;
        r.sat   = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mvm_result_buf.sv
// K-entry result buffer for the MVM drain.
//   clk     : clock
//   wr_en   : write buf[wr_addr] <= wr_data at the clock edge
//   wr_addr : write row
//   wr_data : (saturated) result to store
//   rd_addr : asynchronous read row
//   rd_data : buf[rd_addr], combinational
// Contents are not reset; the drain FSM never reads a row before writing it.
module mvm_result_buf #(
  parameter int K     = 8,
  parameter int W     = 32,
  parameter int IDX_W = $clog2(K)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [W-1:0]     wr_data,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [W-1:0]     rd_data
);

  logic [W-1:0] mem_q [K];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/mvm_result_drain.sv
// Drains the K results of one MVM job into a valid/ready stream.
// After the core's done pulse, waits CAP_LAT cycles, captures K consecutive
// words from mvm_data (optionally saturated to OUT_W), then presents them
// in row order with index/last tags. The core is never stalled: a done
// pulse arriving while a job is in flight is dropped and flagged.
//   clk, reset   : clock, synchronous active-high reset
//   mvm_done     : one-cycle job-complete pulse from the core
//   mvm_data     : signed result stream from the core
//   out_valid    : out_data holds a result
//   out_ready    : consumer accepts on out_valid & out_ready
//   out_data     : signed (saturated) result
//   out_index    : row of out_data
//   out_last     : high with row K-1
//   busy         : a job is in flight
//   overrun      : sticky, a done pulse was dropped
//   sat_seen     : sticky, a word was clamped in the current/last job
//   clear_flags  : clears overrun and sat_seen (a same-cycle set wins)
module mvm_result_drain
  import mvm_pkg::*;
#(
  parameter int K       = 8,
  parameter int IN_W    = 32,
  parameter int OUT_W   = 32,
  parameter int CAP_LAT = 2,
  parameter int IDX_W   = $clog2(K)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mvm_done,
  input  logic [IN_W-1:0]  mvm_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last,
  output logic             busy,
  output logic             overrun,
  output logic             sat_seen,
  input  logic             clear_flags
);

  localparam int               WAIT_W    = (CAP_LAT > 1) ? $clog2(CAP_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(CAP_LAT - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(K - 1);

  mvm_drain_state_t  state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [IDX_W-1:0]  cap_idx_q, cap_idx_d;
  logic              out_valid_q, out_valid_d;
  logic [OUT_W-1:0]  out_data_q, out_data_d;
  logic [IDX_W-1:0]  out_index_q, out_index_d;
  logic              out_last_q, out_last_d;
  logic              overrun_q, overrun_d;
  logic              sat_seen_q, sat_seen_d;

  logic                        hs;
  logic [IDX_W-1:0]            idx_next;
  logic signed [SAT_MAX_W-1:0] mvm_ext;
  sat_result_t                 sat_res;
  logic [OUT_W-1:0]            sat_data;
  logic                        unused_sat_bits;

  logic              buf_wr_en;
  logic [IDX_W-1:0]  buf_rd_addr;
  logic [OUT_W-1:0]  buf_rd_data;

  assign hs       = out_valid_q & out_ready;
  assign idx_next = out_index_q + IDX_W'(1);

  assign mvm_ext         = SAT_MAX_W'(signed'(mvm_data));
  assign sat_res         = sat_trunc(mvm_ext, IN_W, OUT_W);
  assign sat_data        = sat_res.value[OUT_W-1:0];
  assign unused_sat_bits = ^sat_res.value[SAT_MAX_W-1:OUT_W];

  mvm_result_buf #(
    .K     (K),
    .W     (OUT_W),
    .IDX_W (IDX_W)
  ) u_buf (
    .clk     (clk),
    .wr_en   (buf_wr_en),
    .wr_addr (cap_idx_q),
    .wr_data (sat_data),
    .rd_addr (buf_rd_addr),
    .rd_data (buf_rd_data)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (mvm_done) state_d = (CAP_LAT == 1) ? CAPTURE : WAIT;
      end
      WAIT: begin
        // Counter holds cycles left in WAIT; leaving when it would hit 0
        // puts the first capture exactly CAP_LAT cycles after done.
        if (wait_cnt_q == WAIT_W'(1)) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (cap_idx_q == LAST_IDX) state_d = DRAIN;
      end
      DRAIN: begin
        if (hs && out_last_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counters, buffer control, output register and flag updates
  always_comb begin
    wait_cnt_d  = wait_cnt_q;
    cap_idx_d   = cap_idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;
    overrun_d   = overrun_q;
    sat_seen_d  = sat_seen_q;
    buf_wr_en   = 1'b0;
    buf_rd_addr = '0;

    // Clear first so any set below in the same cycle takes priority.
    if (clear_flags) begin
      overrun_d  = 1'b0;
      sat_seen_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (mvm_done) begin
          wait_cnt_d = WAIT_LOAD;
          cap_idx_d  = '0;
          sat_seen_d = 1'b0;
        end
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q - WAIT_W'(1);
      end
      CAPTURE: begin
        buf_wr_en = 1'b1;
        cap_idx_d = cap_idx_q + IDX_W'(1);
        if (sat_res.sat) sat_seen_d = 1'b1;
        if (cap_idx_q == LAST_IDX) begin
          // Preload row 0 so it is visible the cycle after the last capture.
          // With K==1 row 0 is being written this very edge, so bypass.
          cap_idx_d   = '0;
          out_valid_d = 1'b1;
          out_index_d = '0;
          out_last_d  = (K == 1);
          out_data_d  = (cap_idx_q == '0) ? sat_data : buf_rd_data;
        end
      end
      DRAIN: begin
        // Look one row ahead so a handshake can advance every cycle.
        buf_rd_addr = idx_next;
        if (hs) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_index_d = '0;
            out_last_d  = 1'b0;
            out_data_d  = '0;
          end else begin
            out_index_d = idx_next;
            out_data_d  = buf_rd_data;
            out_last_d  = (idx_next == LAST_IDX);
          end
        end
      end
      default: ;
    endcase

    if (mvm_done && (state_q != IDLE)) overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q  <= '0;
      cap_idx_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
      overrun_q   <= 1'b0;
      sat_seen_q  <= 1'b0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      cap_idx_q   <= cap_idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
      overrun_q   <= overrun_d;
      sat_seen_q  <= sat_seen_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != IDLE);
  assign overrun   = overrun_q;
  assign sat_seen  = sat_seen_q;

endmodule

// File: tb/tb_mvm_result_drain.sv
// Bench for mvm_result_drain: a full-width instance (a_*) and a 16-bit
// saturating instance (b_*) share all inputs. The reference model treats a
// job as "K words go in, the same K words (clamped for b) come out in order".
module tb_mvm_result_drain;

  localparam int K       = 8;
  localparam int IN_W    = 32;
  localparam int CAP_LAT = 2;
  localparam int IDX_W   = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             mvm_done = 1'b0;
  logic [IN_W-1:0]  mvm_data = '0;
  logic             out_ready = 1'b0;
  logic             clear_flags = 1'b0;

  logic             a_valid, a_last, a_busy, a_overrun, a_sat;
  logic [31:0]      a_data;
  logic [IDX_W-1:0] a_index;
  logic             b_valid, b_last, b_busy, b_overrun, b_sat;
  logic [15:0]      b_data;
  logic [IDX_W-1:0] b_index;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] jobs_y [2][K];

  always #5 clk = ~clk;

  mvm_result_drain #(.K(K), .IN_W(IN_W), .OUT_W(32), .CAP_LAT(CAP_LAT), .IDX_W(IDX_W)) dut_a (
    .clk(clk), .reset(reset), .mvm_done(mvm_done), .mvm_data(mvm_data),
    .out_valid(a_valid), .out_ready(out_ready), .out_data(a_data), .out_index(a_index),
    .out_last(a_last), .busy(a_busy), .overrun(a_overrun), .sat_seen(a_sat),
    .clear_flags(clear_flags)
  );

  mvm_result_drain #(.K(K), .IN_W(IN_W), .OUT_W(16), .CAP_LAT(CAP_LAT), .IDX_W(IDX_W)) dut_b (
    .clk(clk), .reset(reset), .mvm_done(mvm_done), .mvm_data(mvm_data),
    .out_valid(b_valid), .out_ready(out_ready), .out_data(b_data), .out_index(b_index),
    .out_last(b_last), .busy(b_busy), .overrun(b_overrun), .sat_seen(b_sat),
    .clear_flags(clear_flags)
  );

  function automatic logic [15:0] sat16(input logic [31:0] v);
    int s;
    s = $signed(v);
    if (s > 32767)  return 16'h7fff;
    if (s < -32768) return 16'h8000;
    return v[15:0];
  endfunction

  function automatic bit sat16_hit(input logic [31:0] v);
    int s;
    s = $signed(v);
    return (s > 32767) || (s < -32768);
  endfunction

  function automatic logic [31:0] rand_word();
    int s;
    case ($urandom_range(0, 3))
      0:       s = int'($urandom_range(0, 65535)) - 32768;
      1:       s = int'($urandom_range(0, 200)) - 100;
      2:       s = int'($urandom_range(0, 200000)) - 100000;
      default: s = int'($urandom);
    endcase
    return s;
  endfunction

  // Runs n_jobs jobs (the second, if any, starts in the cycle right after
  // the last handshake of the first). ready_mode: 0 always, 1 pattern
  // 1,0,0, 2 random. ovr_at/clr_at: cycle of an extra done / clear pulse.
  task automatic run_jobs(input int n_jobs, input int ready_mode, input int ovr_at,
                          input int clr_at, input bit chk_timing, input bit chk_sat,
                          input string name);
    logic [31:0] sched [int];
    logic [31:0] exp_a [$];
    logic [15:0] exp_b [$];
    int          exp_i [$];
    int          started = 0, next_start = 0, hs_a = 0, hs_b = 0;
    int          last_hs = -1, first_valid = -1;
    bit          stall_a = 0, stall_b = 0, finished = 0, start_now, exp_s, r;
    logic [31:0] prev_a;
    logic [15:0] prev_b;
    logic [IDX_W-1:0] prev_ia, prev_ib;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      case (ready_mode)
        0:       r = 1'b1;
        1:       r = (c % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase

      if (stall_a) begin
        n_vec++;
        if (a_valid !== 1'b1 || a_data !== prev_a || a_index !== prev_ia) begin
          n_err++;
          $display("FAIL %s stall_hold_a c=%0d got v=%b d=%0h i=%0d need v=1 d=%0h i=%0d",
                   name, c, a_valid, a_data, a_index, prev_a, prev_ia);
        end
      end
      if (stall_b) begin
        n_vec++;
        if (b_valid !== 1'b1 || b_data !== prev_b || b_index !== prev_ib) begin
          n_err++;
          $display("FAIL %s stall_hold_b c=%0d got v=%b d=%0h i=%0d need v=1 d=%0h i=%0d",
                   name, c, b_valid, b_data, b_index, prev_b, prev_ib);
        end
      end
      stall_a = a_valid && !r;  prev_a = a_data;  prev_ia = a_index;
      stall_b = b_valid && !r;  prev_b = b_data;  prev_ib = b_index;

      if (a_valid === 1'b1 && first_valid < 0) first_valid = c;

      if (a_valid === 1'b1 && r) begin
        n_vec++;
        if (hs_a >= exp_a.size()) begin
          n_err++;
          $display("FAIL %s extra_word_a c=%0d got d=%0h need no word", name, c, a_data);
        end else if (a_data !== exp_a[hs_a] || a_index !== IDX_W'(exp_i[hs_a]) ||
                     a_last !== (exp_i[hs_a] == K - 1)) begin
          n_err++;
          $display("FAIL %s word_a#%0d got d=%0h i=%0d l=%b need d=%0h i=%0d l=%b", name, hs_a,
                   a_data, a_index, a_last, exp_a[hs_a], exp_i[hs_a], exp_i[hs_a] == K - 1);
        end
        hs_a++;
        last_hs = c;
        if (hs_a % K == 0 && started < n_jobs) next_start = c + 1;
      end
      if (b_valid === 1'b1 && r) begin
        n_vec++;
        if (hs_b >= exp_b.size()) begin
          n_err++;
          $display("FAIL %s extra_word_b c=%0d got d=%0h need no word", name, c, b_data);
        end else if (b_data !== exp_b[hs_b] || b_index !== IDX_W'(exp_i[hs_b]) ||
                     b_last !== (exp_i[hs_b] == K - 1)) begin
          n_err++;
          $display("FAIL %s word_b#%0d got d=%0h i=%0d l=%b need d=%0h i=%0d l=%b", name, hs_b,
                   b_data, b_index, b_last, exp_b[hs_b], exp_i[hs_b], exp_i[hs_b] == K - 1);
        end
        hs_b++;
      end

      if (chk_sat && c >= 1 && c <= CAP_LAT + K + 1) begin
        exp_s = 1'b0;
        for (int j = 0; j < K; j++)
          if (CAP_LAT + j <= c - 1 && sat16_hit(jobs_y[0][j])) exp_s = 1'b1;
        n_vec++;
        if (b_sat !== exp_s || a_sat !== 1'b0) begin
          n_err++;
          $display("FAIL %s sat_seen c=%0d got a=%b b=%b need a=0 b=%b", name, c, a_sat, b_sat, exp_s);
        end
      end

      if (chk_timing && c == 1) begin
        n_vec++;
        if (a_busy !== 1'b1) begin
          n_err++;
          $display("FAIL %s busy_after_done got %b need 1", name, a_busy);
        end
      end

      if (hs_a == n_jobs * K && c == last_hs + 1) begin
        n_vec++;
        if (a_valid !== 1'b0 || a_busy !== 1'b0 || b_valid !== 1'b0 || b_busy !== 1'b0) begin
          n_err++;
          $display("FAIL %s tail_idle got va=%b ba=%b vb=%b bb=%b need all 0", name,
                   a_valid, a_busy, b_valid, b_busy);
        end
      end
      if (hs_a == n_jobs * K && c == last_hs + 4) begin
        n_vec++;
        if (a_busy !== 1'b0 || a_valid !== 1'b0 || hs_b != n_jobs * K) begin
          n_err++;
          $display("FAIL %s end_state got busy=%b valid=%b hs_b=%0d need 0 0 %0d", name,
                   a_busy, a_valid, hs_b, n_jobs * K);
        end
        finished = 1'b1;
      end

      start_now = (c == next_start) && (started < n_jobs);
      if (start_now) begin
        for (int j = 0; j < K; j++) begin
          sched[c + CAP_LAT + j] = jobs_y[started][j];
          exp_a.push_back(jobs_y[started][j]);
          exp_b.push_back(sat16(jobs_y[started][j]));
          exp_i.push_back(j);
        end
        started++;
      end
      mvm_done    = start_now || (c == ovr_at);
      clear_flags = (c == clr_at);
      mvm_data    = sched.exists(c) ? sched[c] : $urandom;
      out_ready   = r;
      if (finished) break;
    end
    mvm_done    = 1'b0;
    clear_flags = 1'b0;
    out_ready   = 1'b0;

    n_vec++;
    if (!finished) begin
      n_err++;
      $display("FAIL %s timeout got hs=%0d need %0d", name, hs_a, n_jobs * K);
    end
    if (chk_timing) begin
      n_vec++;
      if (first_valid != CAP_LAT + K || last_hs != CAP_LAT + 2 * K - 1) begin
        n_err++;
        $display("FAIL %s timing got first=%0d last=%0d need %0d %0d", name,
                 first_valid, last_hs, CAP_LAT + K, CAP_LAT + 2 * K - 1);
      end
    end
    n_vec++;
    if (a_overrun !== (ovr_at >= 0) || b_overrun !== (ovr_at >= 0)) begin
      n_err++;
      $display("FAIL %s overrun got a=%b b=%b need %b", name, a_overrun, b_overrun, ovr_at >= 0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (a_valid !== 1'b0 || a_data !== '0 || a_index !== '0 || a_last !== 1'b0 ||
        a_busy !== 1'b0 || a_overrun !== 1'b0 || a_sat !== 1'b0 ||
        b_valid !== 1'b0 || b_data !== '0 || b_busy !== 1'b0 || b_sat !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state got va=%b da=%0h ia=%0d la=%b busy=%b ovr=%b sat=%b vb=%b need all 0",
               a_valid, a_data, a_index, a_last, a_busy, a_overrun, a_sat, b_valid);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    for (int j = 0; j < K; j++) jobs_y[0][j] = j + 1;
    run_jobs(1, 0, -1, -1, 1'b1, 1'b1, "basic");
  endtask

  task automatic test_stall();
    for (int j = 0; j < K; j++) jobs_y[0][j] = j + 1;
    run_jobs(1, 1, -1, -1, 1'b0, 1'b1, "stall");
  endtask

  task automatic test_clear_flags(input string name);
    @(negedge clk);
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    n_vec++;
    if (a_overrun !== 1'b0 || a_sat !== 1'b0 || b_overrun !== 1'b0 || b_sat !== 1'b0) begin
      n_err++;
      $display("FAIL %s clear got ovr=%b/%b sat=%b/%b need 0", name, a_overrun, b_overrun, a_sat, b_sat);
    end
  endtask

  task automatic test_saturation();
    jobs_y[0][0] = 32'd40000;
    jobs_y[0][1] = -32'sd40000;
    jobs_y[0][2] = 32'd32767;
    jobs_y[0][3] = -32'sd32768;
    jobs_y[0][4] = 32'd0;
    for (int j = 5; j < K; j++) jobs_y[0][j] = rand_word();
    run_jobs(1, 0, -1, -1, 1'b0, 1'b1, "saturation");
    n_vec++;
    if (b_sat !== 1'b1) begin
      n_err++;
      $display("FAIL saturation sticky got %b need 1", b_sat);
    end
    test_clear_flags("sat_clear");
  endtask

  task automatic test_overrun();
    for (int j = 0; j < K; j++) jobs_y[0][j] = rand_word();
    // extra done mid-capture, with clear_flags in the same cycle: set wins
    run_jobs(1, 2, 5, 5, 1'b0, 1'b0, "overrun");
    test_clear_flags("ovr_clear");
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 6) begin
        n_vec++;
        if (a_overrun !== 1'b1) begin
          n_err++;
          $display("FAIL reset_mid pre_overrun got %b need 1", a_overrun);
        end
      end
      if (c == 7) begin
        n_vec++;
        if (a_valid !== 1'b0 || a_busy !== 1'b0 || a_overrun !== 1'b0 || b_sat !== 1'b0 ||
            b_busy !== 1'b0) begin
          n_err++;
          $display("FAIL reset_mid after got v=%b busy=%b ovr=%b sat=%b need 0", a_valid, a_busy,
                   a_overrun, b_sat);
        end
      end
      if (c > 7 && (a_valid !== 1'b0 || b_valid !== 1'b0)) begin
        n_vec++;
        n_err++;
        $display("FAIL reset_mid partial_output c=%0d got valid=%b need 0", c, a_valid);
      end
      mvm_done  = (c == 0) || (c == 4);
      mvm_data  = (c >= CAP_LAT) ? 32'd70000 + 32'(c) : 32'd0;
      reset     = (c == 6);
      out_ready = 1'b1;
    end
    mvm_done = 1'b0;
    for (int j = 0; j < K; j++) jobs_y[0][j] = j + 9;
    run_jobs(1, 0, -1, -1, 1'b1, 1'b1, "after_reset");
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 2; n++)
      for (int j = 0; j < K; j++) jobs_y[n][j] = rand_word();
    run_jobs(2, 2, -1, -1, 1'b0, 1'b0, "back_to_back");
    for (int n = 0; n < 2; n++)
      for (int j = 0; j < K; j++) jobs_y[n][j] = rand_word();
    run_jobs(2, 0, -1, -1, 1'b0, 1'b0, "back_to_back_full");
  endtask

  task automatic test_random();
    for (int t = 0; t < 4; t++) begin
      for (int j = 0; j < K; j++) jobs_y[0][j] = rand_word();
      run_jobs(1, 2, -1, -1, 1'b0, 1'b1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_saturation();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
